vx_commit_arb: RTL and testbench
================================

# vx_commit_arb

Packet-atomic round-robin arbiter that shares one commit/writeback port among NUM_REQS execution-unit commit streams. Each stream carries commit packets (uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop, infl_id) flattened into DATA_WIDTH bits, with sop/eop also broken out as separate signals. The block sits between the functional units' commit outputs and the commit/writeback stage. Its job is to keep multi-beat (pid-split) commits contiguous, register the output for timing, and count retired instructions.

## Interface
- NUM_REQS, 4, number of commit sources (≥1); SEL_W = max(1, clog2(NUM_REQS))
- DATA_WIDTH, 256, width of the flattened commit payload (opaque to the block)
- CNT_WIDTH, 64, width of the retired-instruction counter
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_REQS  per-source packet valid
- in_data  in  NUM_REQS×DATA_WIDTH  per-source payload
- in_sop  in  NUM_REQS  first beat of a commit
- in_eop  in  NUM_REQS  last beat of a commit
- in_ready  out  NUM_REQS  per-source accept
- out_valid  out  1  registered packet valid
- out_data  out  DATA_WIDTH  registered payload
- out_sop, out_eop  out  1 each  registered sop/eop
- out_sel  out  SEL_W  index of the source of the current output beat
- out_ready  in  1  downstream accept
- commit_cnt  out  CNT_WIDTH  number of accepted eop beats since reset

## Operation
- Output stage: one register slot. It can load when `load_en = ~out_valid | out_ready`.
- Arbitration, unlocked:
  - Grant goes to the first requester with in_valid=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQS.
  - No requester valid → no grant.
- Arbitration, locked: grant is forced to lock_idx whatever rr_ptr and other requests are. Other sources see in_ready=0.
- `in_ready[i] = grant[i] & load_en`. At most one in_ready is high per cycle. in_ready may depend combinationally on in_valid and out_ready.
- Accept (in_valid[g] & in_ready[g]):
  - Output register loads {data, sop, eop, g}.
  - If eop=0: lock=1, lock_idx=g.
  - If eop=1: lock=0, rr_ptr=(g+1) mod NUM_REQS, commit_cnt increments.
- Single-beat packets (sop=1, eop=1) never lock.
- sop is not checked. A beat with sop=1 while locked is forwarded unchanged; it does not break the lock. A beat with sop=0 while unlocked is forwarded normally.
- No accept while out_ready=1 → out_valid clears next cycle. No accept while out_ready=0 → output holds, and out_data must stay stable.
- rr_ptr advances only on eop accepts. A source that is locked but stalled (in_valid=0) holds the port; there is no timeout.
- commit_cnt wraps modulo 2^CNT_WIDTH.
- NUM_REQS=1: arbiter degenerates. out_sel=0, in_ready[0]=load_en.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+1.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 → all in_ready=0 in the same cycle.
- Reset (async assert, sync deassert in the enclosing domain) clears: out_valid=0, out_data=0, out_sop=0, out_eop=0, out_sel=0, lock=0, lock_idx=0, rr_ptr=0, commit_cnt=0. in_ready=0 while reset_n=0.
- Reset mid-packet: lock and the pending output beat are dropped. Sources must restart their commits after reset.
- Simultaneous events: an eop accept in cycle N unlocks, and arbitration in cycle N+1 uses the updated rr_ptr. The unlocking source gets lowest priority in N+1.

## Test plan
- Reset: hold reset_n=0 with all in_valid=1 → in_ready=0, out_valid=0, commit_cnt=0. After release, src0 is granted first.
- Round-robin fairness, single-beat packets:
  - Stimulus: NUM_REQS=4, all sources continuously valid, out_ready=1.
  - Expected: out_sel sequence 0,1,2,3,0,…; commit_cnt=8 after 8 beats; one beat per cycle.
- Packet atomicity:
  - Stimulus: src1 sends a 3-beat commit (sop, mid, eop) while src0/2/3 stay valid.
  - Expected: out_sel=1 for three consecutive beats, other in_ready=0 meanwhile; next grant is src2; commit_cnt increases by 1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with out_valid=1.
  - Expected: out_data/out_sel stable, all in_ready=0. On out_ready=1, the held beat retires and a new beat loads the same cycle.
- Stalled lock: src3 sends sop (eop=0), then drops in_valid for 4 cycles while src0 is valid → src0 is never granted until src3 delivers eop.
- Reset mid-packet: assert reset_n=0 after src2's first beat → lock clears. After release with src0 and src2 valid, src0 is granted (rr_ptr=0).

Source files
------------

// File: rtl/vx_commit_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_arb
// Purpose  : Packet-atomic round-robin commit arbiter with registered output
//            and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module vx_commit_arb #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 64,
    localparam int SEL_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQS-1:0]            in_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQS-1:0]            in_sop,
    input  logic [NUM_REQS-1:0]            in_eop,
    output logic [NUM_REQS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [SEL_W-1:0]               out_sel,
    input  logic                           out_ready,
    output logic [CNT_WIDTH-1:0]           commit_cnt
);

    localparam int SUM_W = SEL_W + 1;

    // Output slot and arbitration state
    logic                  out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                  out_sop_q,    out_sop_d;
    logic                  out_eop_q,    out_eop_d;
    logic [SEL_W-1:0]      out_sel_q,    out_sel_d;
    logic                  lock_q,       lock_d;
    logic [SEL_W-1:0]      lock_idx_q,   lock_idx_d;
    logic [SEL_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic [CNT_WIDTH-1:0]  commit_cnt_q, commit_cnt_d;

    logic                  w_load_en;
    logic                  w_grant_found;
    logic [SEL_W-1:0]      w_grant_idx;
    logic [SUM_W-1:0]      w_cand;
    logic                  w_sel_valid;
    logic                  w_sel_sop;
    logic                  w_sel_eop;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;
    logic [SUM_W-1:0]      w_rr_sum;
    logic [SEL_W-1:0]      w_rr_next;

    assign w_load_en = ~out_valid_q | out_ready;

    // A held lock overrides the round-robin scan, even if the owner is idle.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        if (lock_q) begin
            w_grant_found = 1'b1;
            w_grant_idx   = lock_idx_q;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                w_cand = {1'b0, rr_ptr_q} + SUM_W'(k);
                if (w_cand >= SUM_W'(NUM_REQS)) begin
                    w_cand = w_cand - SUM_W'(NUM_REQS);
                end
                if (!w_grant_found && in_valid[w_cand[SEL_W-1:0]]) begin
                    w_grant_found = 1'b1;
                    w_grant_idx   = w_cand[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_sop   = in_sop[i];
                w_sel_eop   = in_eop[i];
                w_sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept = reset_n & w_grant_found & w_sel_valid & w_load_en;

    always_comb begin
        w_rr_sum = {1'b0, w_grant_idx} + SUM_W'(1);
        if (w_rr_sum >= SUM_W'(NUM_REQS)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_rr_sum[SEL_W-1:0];
        end
    end

    generate
        if (NUM_REQS == 1) begin : g_single
            assign in_ready[0] = reset_n & w_load_en;
        end else begin : g_multi
            for (genvar i = 0; i < NUM_REQS; i++) begin : g_ready
                assign in_ready[i] = reset_n & w_grant_found & w_load_en &
                                     (w_grant_idx == SEL_W'(i));
            end
        end
    endgenerate

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_sel_d    = out_sel_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        rr_ptr_d     = rr_ptr_q;
        commit_cnt_d = commit_cnt_q;

        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_sop_d   = w_sel_sop;
            out_eop_d   = w_sel_eop;
            out_sel_d   = w_grant_idx;
            // sop is deliberately ignored: only eop opens or closes a lock
            if (w_sel_eop) begin
                lock_d       = 1'b0;
                rr_ptr_d     = w_rr_next;
                commit_cnt_d = commit_cnt_q + CNT_WIDTH'(1);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = w_grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_sel_q    <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            rr_ptr_q     <= '0;
            commit_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_sel_q    <= out_sel_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_sel    = out_sel_q;
    assign commit_cnt = commit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_commit_arb
// Purpose  : Scoreboard bench for vx_commit_arb (4 sources, 32-bit payload).
// Revision : 1.0
// ============================================================================
module tb_vx_commit_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [NR-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [NR*DW-1:0] in_data;
    logic             out_valid, out_sop, out_eop;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_sel;
    logic [CW-1:0]    commit_cnt;

    vx_commit_arb #(.NUM_REQS(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_sel    (out_sel),
        .out_ready  (out_ready),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          gap;
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [1:0]    sel;
    } beat_t;

    beat_t srcq [NR][$];   // per-source stimulus (gap = idle cycle)
    beat_t expq [NR][$];   // per-source beats expected at the output
    int    selq [$];       // expected output source order

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    logic [NR-1:0] s_acc, s_ready;
    logic          s_valid, s_fire, s_sop, s_eop;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;
    logic [CW-1:0] s_cnt;

    task automatic add_beat(input int s, input bit sop, input bit eop);
        beat_t b;
        tag++;
        b.gap  = 1'b0;
        b.sop  = sop;
        b.eop  = eop;
        b.sel  = 2'(s);
        b.data = (32'(s) << 24) | 32'(tag);
        srcq[s].push_back(b);
        expq[s].push_back(b);
    endtask

    task automatic add_gap(input int s);
        beat_t b;
        b.gap = 1'b1; b.sop = 1'b0; b.eop = 1'b0; b.data = '0; b.sel = 2'(s);
        srcq[s].push_back(b);
    endtask

    task automatic clear_queues();
        for (int s = 0; s < NR; s++) begin
            srcq[s].delete();
            expq[s].delete();
        end
        selq.delete();
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < NR; s++) begin
            if (srcq[s].size() > 0 && !srcq[s][0].gap) begin
                in_valid[s]            = 1'b1;
                in_sop[s]              = srcq[s][0].sop;
                in_eop[s]              = srcq[s][0].eop;
                in_data[s*DW +: DW]    = srcq[s][0].data;
            end else begin
                in_valid[s]            = 1'b0;
                in_sop[s]              = 1'b0;
                in_eop[s]              = 1'b0;
                in_data[s*DW +: DW]    = '0;
            end
        end
    endtask

    // Snapshot at the falling edge, then advance sources past the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_ready = in_ready;
        s_acc   = in_valid & in_ready;
        s_valid = out_valid;
        s_fire  = out_valid & out_ready;
        s_data  = out_data;
        s_sop   = out_sop;
        s_eop   = out_eop;
        s_sel   = out_sel;
        s_cnt   = commit_cnt;
        @(posedge clk);
        #1;
        for (int s = 0; s < NR; s++) begin
            if (srcq[s].size() > 0 && (srcq[s][0].gap || s_acc[s])) begin
                void'(srcq[s].pop_front());
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        clear_queues();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int es; beat_t eb;
        #1;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        clear_queues();
        for (int s = 0; s < NR; s++) begin
            add_beat(s, 1'b1, 1'b1);
            selq.push_back(s);
        end
        drive_inputs();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b, required 0000", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        n_cmp++;
        if (commit_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d, required 0", commit_cnt); end
        n_cmp++;
        if ({out_data, out_sel, out_sop, out_eop} !== '0) begin
            n_bad++; $display("FAIL rst_out: got data=%h sel=%0d, required zero", out_data, out_sel);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 20 && selq.size() > 0; c++) begin
            cycle();
            if (c == 0) begin
                n_cmp++;
                if (s_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant: got %b, required 0001", s_ready); end
            end
            if (s_fire) begin
                n_cmp++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL rst_out_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL rst_out_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
            end
        end
        n_cmp++;
        if (selq.size() != 0) begin n_bad++; $display("FAIL rst_drain: %0d beats missing, required 0", selq.size()); end
        n_cmp++;
        if (commit_cnt !== 32'd4) begin n_bad++; $display("FAIL rst_cnt_end: got %0d, required 4", commit_cnt); end
    endtask

    task automatic test_round_robin();
        int es; beat_t eb; int fires = 0; int first = -1; int last = -1;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < NR; s++) begin
                add_beat(s, 1'b1, 1'b1);
                selq.push_back(s);
            end
        end
        drive_inputs();
        for (int c = 0; c < 30 && selq.size() > 0; c++) begin
            cycle();
            if (s_fire) begin
                n_cmp++;
                if (first < 0) first = c;
                last = c;
                fires++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL rr_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL rr_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
                if (fires == 8) begin
                    n_cmp++;
                    if (s_cnt !== 32'd8) begin n_bad++; $display("FAIL rr_cnt8: got %0d, required 8", s_cnt); end
                end
            end
        end
        n_cmp++;
        if (fires != 12 || last - first != 11) begin
            n_bad++; $display("FAIL rr_rate: got %0d beats over %0d cycles, required 12 over 12", fires, last - first + 1);
        end
        n_cmp++;
        if (commit_cnt !== 32'd12) begin n_bad++; $display("FAIL rr_cnt_end: got %0d, required 12", commit_cnt); end
    endtask

    task automatic test_atomicity();
        int es; beat_t eb; int multi = 0; int n1 = 0; int f1 = -1; int l1 = -1;
        do_reset();
        for (int k = 0; k < 2; k++) add_beat(0, 1'b1, 1'b1);
        add_beat(1, 1'b1, 1'b0);
        add_beat(1, 1'b0, 1'b0);
        add_beat(1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            add_beat(2, 1'b1, 1'b1);
            add_beat(3, 1'b1, 1'b1);
        end
        foreach (selq[i]) ;
        selq = '{0, 1, 1, 1, 2, 3, 0, 2, 3};
        drive_inputs();
        for (int c = 0; c < 30 && selq.size() > 0; c++) begin
            cycle();
            if ($countones(s_ready) > 1) multi++;
            if (s_acc[1]) begin
                n1++;
                if (f1 < 0) f1 = c;
                l1 = c;
                n_cmp++;
                if (s_ready !== 4'b0010) begin n_bad++; $display("FAIL atom_ready: got %b, required 0010", s_ready); end
            end
            if (s_fire) begin
                n_cmp++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL atom_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL atom_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
            end
        end
        n_cmp++;
        if (n1 != 3 || l1 - f1 != 2) begin n_bad++; $display("FAIL atom_contig: got %0d beats span %0d, required 3 span 2", n1, l1 - f1); end
        n_cmp++;
        if (multi != 0) begin n_bad++; $display("FAIL atom_onehot: got %0d multi-ready cycles, required 0", multi); end
        n_cmp++;
        if (selq.size() != 0) begin n_bad++; $display("FAIL atom_drain: %0d beats missing, required 0", selq.size()); end
        n_cmp++;
        if (commit_cnt !== 32'd7) begin n_bad++; $display("FAIL atom_cnt: got %0d, required 7", commit_cnt); end
    endtask

    task automatic test_backpressure();
        int es; beat_t eb; logic [DW-1:0] held;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            add_beat(0, 1'b1, 1'b1);
            add_beat(1, 1'b1, 1'b1);
        end
        selq = '{0, 1, 0, 1};
        held = expq[0][0].data;
        drive_inputs();
        cycle();
        n_cmp++;
        if ({s_valid, s_ready} !== {1'b0, 4'b0001}) begin
            n_bad++; $display("FAIL bp_first: got valid=%b ready=%b, required valid=0 ready=0001", s_valid, s_ready);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_cmp++;
            if ({s_valid, s_ready, s_sel, s_data} !== {1'b1, 4'b0000, 2'd0, held}) begin
                n_bad++; $display("FAIL bp_hold: got valid=%b ready=%b sel=%0d data=%h, required valid=1 ready=0000 sel=0 data=%h",
                                  s_valid, s_ready, s_sel, s_data, held);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && selq.size() > 0; c++) begin
            cycle();
            if (c == 0) begin
                n_cmp++;
                if ({s_fire, s_ready} !== {1'b1, 4'b0010}) begin
                    n_bad++; $display("FAIL bp_release: got fire=%b ready=%b, required fire=1 ready=0010", s_fire, s_ready);
                end
            end
            if (s_fire) begin
                n_cmp++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL bp_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL bp_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
            end
        end
        n_cmp++;
        if (selq.size() != 0) begin n_bad++; $display("FAIL bp_drain: %0d beats missing, required 0", selq.size()); end
    endtask

    task automatic test_stalled_lock();
        int es; beat_t eb; bit lk = 1'b0; int n_lock = 0;
        do_reset();
        for (int k = 0; k < 3; k++) add_beat(0, 1'b1, 1'b1);
        add_beat(3, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) add_gap(3);
        add_beat(3, 1'b0, 1'b1);
        selq = '{0, 3, 3, 0, 0};
        drive_inputs();
        for (int c = 0; c < 30 && selq.size() > 0; c++) begin
            cycle();
            if (lk) begin
                n_lock++;
                n_cmp++;
                if (s_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_ready: got %b, required 1000", s_ready); end
            end
            if (s_acc[3]) lk = ~lk;
            if (s_fire) begin
                n_cmp++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL stall_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL stall_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
            end
        end
        n_cmp++;
        if (n_lock != 5) begin n_bad++; $display("FAIL stall_len: got %0d locked cycles, required 5", n_lock); end
        n_cmp++;
        if (selq.size() != 0) begin n_bad++; $display("FAIL stall_drain: %0d beats missing, required 0", selq.size()); end
        n_cmp++;
        if (commit_cnt !== 32'd4) begin n_bad++; $display("FAIL stall_cnt: got %0d, required 4", commit_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        int es; beat_t eb;
        do_reset();
        add_beat(2, 1'b1, 1'b0);
        add_beat(2, 1'b0, 1'b0);
        add_beat(2, 1'b0, 1'b1);
        drive_inputs();
        cycle();
        n_cmp++;
        if (s_acc !== 4'b0100) begin n_bad++; $display("FAIL mid_first: got %b, required 0100", s_acc); end
        reset_n = 1'b0;
        clear_queues();
        drive_inputs();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, commit_cnt} !== {1'b0, 4'b0000, 32'd0}) begin
            n_bad++; $display("FAIL mid_reset: got valid=%b ready=%b cnt=%0d, required 0/0000/0", out_valid, in_ready, commit_cnt);
        end
        add_beat(0, 1'b1, 1'b1);
        add_beat(2, 1'b1, 1'b1);
        selq = '{0, 2};
        drive_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 20 && selq.size() > 0; c++) begin
            cycle();
            if (c == 0) begin
                n_cmp++;
                if (s_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_regrant: got %b, required 0001", s_ready); end
            end
            if (s_fire) begin
                n_cmp++;
                if (selq.size() == 0) begin
                    n_bad++; $display("FAIL mid_beat: extra beat sel=%0d, required none", s_sel);
                end else begin
                    es = selq.pop_front(); eb = expq[es].pop_front();
                    if ({s_sel, s_sop, s_eop, s_data} !== {eb.sel, eb.sop, eb.eop, eb.data}) begin
                        n_bad++; $display("FAIL mid_beat: got sel=%0d data=%h, required sel=%0d data=%h", s_sel, s_data, eb.sel, eb.data);
                    end
                end
            end
        end
        n_cmp++;
        if (selq.size() != 0) begin n_bad++; $display("FAIL mid_drain: %0d beats missing, required 0", selq.size()); end
        n_cmp++;
        if (commit_cnt !== 32'd2) begin n_bad++; $display("FAIL mid_cnt: got %0d, required 2", commit_cnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_atomicity();
        test_backpressure();
        test_stalled_lock();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
